// File: rtl/red_pitaya_filter_cfg_seq.sv
// Filter configuration sequencer: shadow-latches a word, applies it now or on sync, then holds.
// Optional FILTER_CFG_SEQ_STAGGER_EN applies one stage byte per cycle, stage 0 first.
`timescale 1ns / 1ps

module red_pitaya_filter_cfg_seq #(
  parameter int unsigned STAGES     = 4,
  parameter int unsigned SETTLEBITS = 16
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [31:0]           cfg_i,
  input  logic                  cfg_valid_i,
  output logic                  cfg_ready_o,
  input  logic                  sync_mode_i,
  input  logic                  sync_i,
  input  logic                  abort_i,
  input  logic [SETTLEBITS-1:0] settle_i,
  output logic [31:0]           set_filter_o,
  output logic                  apply_o,
  output logic                  hold_o,
  output logic                  busy_o
);

  typedef enum logic [1:0] {StIdle, StArmed, StApply, StSettle} state_e;

  // Bytes of stages that are not in use are forced to zero at accept.
  localparam logic [31:0] StageMask = (STAGES >= 4) ? 32'hFFFF_FFFF :
                                      ((32'd1 << (8 * STAGES)) - 32'd1);

  state_e                state_q;
  logic [31:0]           shadow_q;
  logic [SETTLEBITS-1:0] settle_q;
  logic [SETTLEBITS-1:0] cnt_q;

`ifdef FILTER_CFG_SEQ_STAGGER_EN
  localparam logic [1:0] LastStg = 2'(STAGES - 1);
  logic [1:0] stg_q;
`endif

  assign cfg_ready_o = (state_q == StIdle);
  assign busy_o      = (state_q != StIdle);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= StIdle;
      shadow_q     <= '0;
      settle_q     <= '0;
      cnt_q        <= '0;
      set_filter_o <= '0;
      apply_o      <= 1'b0;
      hold_o       <= 1'b0;
`ifdef FILTER_CFG_SEQ_STAGGER_EN
      stg_q        <= '0;
`endif
    end else begin
      apply_o <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cfg_valid_i) begin
            shadow_q <= cfg_i & StageMask;
            settle_q <= settle_i;
            state_q  <= sync_mode_i ? StArmed : StApply;
`ifdef FILTER_CFG_SEQ_STAGGER_EN
            stg_q    <= '0;
`endif
          end
        end
        StArmed: begin
          // Abort has priority over a coincident sync strobe.
          if (abort_i) begin
            state_q <= StIdle;
          end else if (sync_i) begin
            state_q <= StApply;
          end
        end
        StApply: begin
`ifdef FILTER_CFG_SEQ_STAGGER_EN
          set_filter_o[{stg_q, 3'b000} +: 8] <= shadow_q[{stg_q, 3'b000} +: 8];
          if (stg_q == 2'd0 && settle_q != '0) begin
            hold_o <= 1'b1;
          end
          if (stg_q == LastStg) begin
            apply_o <= 1'b1;
            if (settle_q != '0) begin
              state_q <= StSettle;
              hold_o  <= 1'b1;
              cnt_q   <= settle_q - SETTLEBITS'(1);
            end else begin
              state_q <= StIdle;
            end
          end else begin
            stg_q <= stg_q + 2'd1;
          end
`else
          set_filter_o <= shadow_q;
          apply_o      <= 1'b1;
          if (settle_q != '0) begin
            state_q <= StSettle;
            hold_o  <= 1'b1;
            cnt_q   <= settle_q - SETTLEBITS'(1);
          end else begin
            state_q <= StIdle;
          end
`endif
        end
        StSettle: begin
          if (abort_i || cnt_q == '0) begin
            hold_o  <= 1'b0;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - SETTLEBITS'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_red_pitaya_filter_cfg_seq.sv
// Self-checking bench for red_pitaya_filter_cfg_seq; expected words are queued at stimulus time
// and compared when apply_o pulses.
`timescale 1ns / 1ps

module tb_red_pitaya_filter_cfg_seq;

`ifdef FILTER_CFG_SEQ_STAGGER_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] cfg = '0;
  logic        valid = 1'b0;
  logic        sync_mode = 1'b0;
  logic        sync = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] settle = '0;
  logic        ready, apply, hold, busy;
  logic [31:0] set_filter;
  logic        ready2, apply2, hold2, busy2;
  logic [31:0] set_filter2;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          apply_cnt = 0;
  int          last_apply_cyc = 0;
  logic [31:0] exp_q[$];
  logic [31:0] cur_filter = '0;

  always #5 clk = ~clk;

  red_pitaya_filter_cfg_seq #(.STAGES(4), .SETTLEBITS(16)) u_dut (
    .clk_i(clk), .rstn_i(rstn), .cfg_i(cfg), .cfg_valid_i(valid), .cfg_ready_o(ready),
    .sync_mode_i(sync_mode), .sync_i(sync), .abort_i(abort), .settle_i(settle),
    .set_filter_o(set_filter), .apply_o(apply), .hold_o(hold), .busy_o(busy)
  );

  red_pitaya_filter_cfg_seq #(.STAGES(2), .SETTLEBITS(16)) u_dut2 (
    .clk_i(clk), .rstn_i(rstn), .cfg_i(cfg), .cfg_valid_i(valid), .cfg_ready_o(ready2),
    .sync_mode_i(sync_mode), .sync_i(sync), .abort_i(abort), .settle_i(settle),
    .set_filter_o(set_filter2), .apply_o(apply2), .hold_o(hold2), .busy_o(busy2)
  );

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Scoreboard: every apply pulse must match the oldest queued word.
  initial forever begin
    logic [31:0] exp_w;
    @(negedge clk);
    if (apply === 1'b1) begin
      apply_cnt++;
      last_apply_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL apply_unexpected: apply_o high with nothing queued, set_filter=%h",
                 set_filter);
      end else begin
        exp_w = exp_q.pop_front();
        if (set_filter !== exp_w) begin
          errors++;
          $display("FAIL apply_word: set_filter=%h expected %h", set_filter, exp_w);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w, input logic [15:0] s, input logic sm);
    int n = 0;
    cfg = w; settle = s; sync_mode = sm; valid = 1'b1;
    while (ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL send_timeout: cfg_ready_o=%b expected 1", ready);
    end
    tick();
    valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
    if (busy !== 1'b0) begin
      checks++; errors++;
      $display("FAIL idle_timeout: busy_o=%b expected 0", busy);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    #2;
    checks += 6;
    if (set_filter !== 32'h0) begin errors++; $display("FAIL rst_set_filter: got %h expected 0", set_filter); end
    if (ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b expected 1", ready); end
    if (apply !== 1'b0) begin errors++; $display("FAIL rst_apply: got %b expected 0", apply); end
    if (hold !== 1'b0) begin errors++; $display("FAIL rst_hold: got %b expected 0", hold); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    if (set_filter2 !== 32'h0) begin errors++; $display("FAIL rst_set_filter2: got %h expected 0", set_filter2); end
    #10;
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_immediate();
    logic [31:0] w = 32'h0000_8C85;
    int s = 3;
    exp_q.push_back(w);
    send(w, 16'(s), 1'b0);
    for (int i = 0; i <= LAT + s + 1; i++) begin
      @(negedge clk);
      checks += 3;
      if (hold !== (i >= 1 && i <= LAT + s - 1)) begin
        errors++; $display("FAIL imm_hold[%0d]: got %b expected %b", i, hold, (i >= 1 && i <= LAT + s - 1));
      end
      if (apply !== (i == LAT)) begin
        errors++; $display("FAIL imm_apply[%0d]: got %b expected %b", i, apply, (i == LAT));
      end
      if (ready !== (i >= LAT + s)) begin
        errors++; $display("FAIL imm_ready[%0d]: got %b expected %b", i, ready, (i >= LAT + s));
      end
    end
    cur_filter = w;
  endtask

  task automatic test_stages();
    wait_idle();
    exp_q.push_back(32'hFFFF_FFFF);
    send(32'hFFFF_FFFF, 16'd0, 1'b0);
    wait_idle();
    checks += 2;
    if (set_filter !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL stages4_word: got %h expected ffffffff", set_filter);
    end
    if (set_filter2 !== 32'h0000_FFFF) begin
      errors++; $display("FAIL stages2_word: got %h expected 0000ffff", set_filter2);
    end
    cur_filter = 32'hFFFF_FFFF;
  endtask

  task automatic test_sync();
    logic [31:0] w = 32'h8A8B_0C06;
    exp_q.push_back(w);
    send(w, 16'd2, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks += 2;
      if (set_filter !== cur_filter) begin
        errors++; $display("FAIL sync_early[%0d]: got %h expected %h", i, set_filter, cur_filter);
      end
      if (busy !== 1'b1) begin errors++; $display("FAIL sync_busy[%0d]: got %b expected 1", i, busy); end
    end
    sync = 1'b1;
    tick();
    sync = 1'b0;
    @(negedge clk);
    checks++;
    if (set_filter !== cur_filter) begin
      errors++; $display("FAIL sync_edge: got %h expected %h", set_filter, cur_filter);
    end
    for (int i = 1; i <= LAT; i++) @(negedge clk);
    checks += 3;
    if (apply !== 1'b1) begin errors++; $display("FAIL sync_apply: got %b expected 1", apply); end
    if (set_filter !== w) begin errors++; $display("FAIL sync_word: got %h expected %h", set_filter, w); end
    if (busy !== 1'b1) begin errors++; $display("FAIL sync_busy_settle: got %b expected 1", busy); end
    wait_idle();
    cur_filter = w;
  endtask

  task automatic test_abort_sync();
    send(32'h1234_5678, 16'd5, 1'b1);
    tick();
    tick();
    abort = 1'b1;
    sync = 1'b1;
    tick();
    abort = 1'b0;
    sync = 1'b0;
    checks += 2;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_sync_busy: got %b expected 0", busy); end
    if (ready !== 1'b1) begin errors++; $display("FAIL abort_sync_ready: got %b expected 1", ready); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks += 2;
      if (set_filter !== cur_filter) begin
        errors++; $display("FAIL abort_sync_word[%0d]: got %h expected %h", i, set_filter, cur_filter);
      end
      if (apply !== 1'b0) begin errors++; $display("FAIL abort_sync_apply[%0d]: got %b expected 0", i, apply); end
    end
  endtask

  task automatic test_abort_settle();
    logic [31:0] w = 32'h8586_8788;
    exp_q.push_back(w);
    send(w, 16'hFFFF, 1'b0);
    repeat (LAT + 4) tick();
    checks++;
    if (hold !== 1'b1) begin errors++; $display("FAIL abort_settle_hold_pre: got %b expected 1", hold); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks += 3;
    if (hold !== 1'b0) begin errors++; $display("FAIL abort_settle_hold: got %b expected 0", hold); end
    if (ready !== 1'b1) begin errors++; $display("FAIL abort_settle_ready: got %b expected 1", ready); end
    if (set_filter !== w) begin errors++; $display("FAIL abort_settle_word: got %h expected %h", set_filter, w); end
    cur_filter = w;
  endtask

  task automatic test_reset_mid();
    logic [31:0] w = 32'h0000_9F8E;
    send(32'hC1C2_C3C4, 16'd4, 1'b1);
    repeat (3) tick();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL armed_busy: got %b expected 1", busy); end
    #2 rstn = 1'b0;
    #1;
    checks += 4;
    if (set_filter !== 32'h0) begin errors++; $display("FAIL rst_armed_word: got %h expected 0", set_filter); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_armed_busy: got %b expected 0", busy); end
    if (ready !== 1'b1) begin errors++; $display("FAIL rst_armed_ready: got %b expected 1", ready); end
    if (hold !== 1'b0) begin errors++; $display("FAIL rst_armed_hold: got %b expected 0", hold); end
    #1 rstn = 1'b1;
    cur_filter = '0;
    exp_q.push_back(w);
    send(w, 16'd50, 1'b0);
    repeat (LAT + 3) tick();
    checks += 2;
    if (hold !== 1'b1) begin errors++; $display("FAIL settle_hold_pre: got %b expected 1", hold); end
    if (set_filter !== w) begin errors++; $display("FAIL settle_word_pre: got %h expected %h", set_filter, w); end
    #2 rstn = 1'b0;
    #1;
    checks += 5;
    if (set_filter !== 32'h0) begin errors++; $display("FAIL rst_settle_word: got %h expected 0", set_filter); end
    if (hold !== 1'b0) begin errors++; $display("FAIL rst_settle_hold: got %b expected 0", hold); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_settle_busy: got %b expected 0", busy); end
    if (ready !== 1'b1) begin errors++; $display("FAIL rst_settle_ready: got %b expected 1", ready); end
    if (apply !== 1'b0) begin errors++; $display("FAIL rst_settle_apply: got %b expected 0", apply); end
    #1 rstn = 1'b1;
    cur_filter = '0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] words[3] = '{32'hA1A2_A3A4, 32'h0000_0081, 32'hA1A2_A3A4};
    int base = apply_cnt;
    int first;
    foreach (words[i]) exp_q.push_back(words[i]);
    send(words[0], 16'd0, 1'b0);
    first = cyc;
    send(words[1], 16'd0, 1'b0);
    send(words[2], 16'd0, 1'b0);
    wait_idle();
    tick();
    checks += 2;
    if (apply_cnt - base !== 3) begin
      errors++; $display("FAIL b2b_count: got %0d applies expected 3", apply_cnt - base);
    end
    if (last_apply_cyc - first !== 2 * (LAT + 1) + LAT) begin
      errors++; $display("FAIL b2b_latency: got %0d cycles expected %0d", last_apply_cyc - first,
                         2 * (LAT + 1) + LAT);
    end
    cur_filter = words[2];
  endtask

`ifdef FILTER_CFG_SEQ_STAGGER_EN
  task automatic test_stagger();
    logic [31:0] w = 32'h4433_2211;
    logic [31:0] exp_w;
    exp_q.push_back(w);
    send(w, 16'd1, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      exp_w = cur_filter;
      for (int b = 0; b < i; b++) exp_w[8*b +: 8] = w[8*b +: 8];
      checks += 2;
      if (set_filter !== exp_w) begin
        errors++; $display("FAIL stagger_word[%0d]: got %h expected %h", i, set_filter, exp_w);
      end
      if (hold !== 1'b1) begin errors++; $display("FAIL stagger_hold[%0d]: got %b expected 1", i, hold); end
    end
    wait_idle();
    cur_filter = w;
  endtask
`endif

  initial begin
    test_reset();
    test_immediate();
    test_stages();
    test_sync();
    test_abort_sync();
    test_abort_settle();
    test_reset_mid();
    test_back_to_back();
`ifdef FILTER_CFG_SEQ_STAGGER_EN
    test_stagger();
`endif
    repeat (3) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_leftover: %0d words never applied, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/red_pitaya_filter_cfg_seq.md
# red_pitaya_filter_cfg_seq

Configuration sequencer for the cascaded low/high-pass filter block. It accepts new 32-bit filter configuration words from a requester via a valid/ready handshake, and holds each word in a shadow register. It applies the word to the filter's `set_filter` input either immediately or on an external sync strobe. After each change it asserts a hold flag for a programmable settle time, so downstream servo logic can freeze while the filter transient decays.

## Interface
- `STAGES`, default 4: number of filter stages in use (1..4); bytes for stages ≥ `STAGES` are forced to 0 on output.
- `SETTLEBITS`, default 16: width of the settle counter.

Ports:
- `clk_i`  in  1  system clock; all logic on its rising edge.
- `rstn_i`  in  1  reset, asynchronous, active-low.
- `cfg_i`  in  32  requested filter word; byte j = stage j: [7] on, [6] highpass, [3:0] shift.
- `cfg_valid_i`  in  1  request valid.
- `cfg_ready_o`  out  1  sequencer can accept a word.
- `sync_mode_i`  in  1  0: apply right after accept; 1: wait for `sync_i`.
- `sync_i`  in  1  apply strobe, sampled only in ARMED.
- `abort_i`  in  1  cancel pending word, or end settle early.
- `settle_i`  in  SETTLEBITS  hold duration in cycles; latched at accept.
- `set_filter_o`  out  32  registered configuration driven to the filter block.
- `apply_o`  out  1  one-cycle pulse, high in the cycle after `set_filter_o` changes.
- `hold_o`  out  1  high during settle.
- `busy_o`  out  1  high whenever state ≠ IDLE.

## Operation
- States: IDLE, ARMED, APPLY, SETTLE.
- Reset values: state IDLE, `set_filter_o`=0 (all stages bypassed), shadow=0, `cfg_ready_o`=1, `apply_o`=0, `hold_o`=0, `busy_o`=0, settle counter=0.
- `cfg_ready_o` = (state==IDLE), combinational from the state register.
- Accept: `cfg_valid_i`&`cfg_ready_o` at an edge. This latches `cfg_i` (stage bytes ≥ `STAGES` zeroed) into the shadow, latches `settle_i`, and moves to APPLY if `sync_mode_i`=0, else to ARMED. `sync_mode_i` is sampled at accept only.
- ARMED:
  - `abort_i`=1 → IDLE, `set_filter_o` unchanged, no `apply_o`.
  - else `sync_i`=1 → APPLY.
  - else stay.
  - Abort beats sync when both are high.
- APPLY (1 cycle): on exit edge, `set_filter_o` ← shadow and `apply_o` is set for one cycle.
  - If latched settle > 0: go to SETTLE, `hold_o`←1, counter ← settle−1.
  - If settle = 0: go to IDLE, `hold_o` stays 0.
- SETTLE: counter decrements each cycle.
  - At counter==0, or when `abort_i`=1: `hold_o`←0 and go to IDLE.
  - `abort_i` in APPLY is ignored.
- Writing an identical word still runs the full sequence, including the pulse and hold.
- `cfg_valid_i` while busy: no accept; the requester holds `cfg_i` stable until ready.

## Timing
- Immediate mode: accept at edge k → `set_filter_o` new and `apply_o`=1 after edge k+1.
- `hold_o`:
  - high from edge k+1 to edge k+1+S (exactly S cycles for settle S ≥ 1).
  - `cfg_ready_o` returns after edge k+1+S.
  - S=0: ready again after edge k+1.
- Sync mode: `sync_i` sampled high at edge m → output update after edge m+1. Sync-to-update latency is 1 cycle.
- Back-to-back throughput without settle: one word per 2 cycles.
- Counter arithmetic is unsigned SETTLEBITS; the maximum hold is 2^SETTLEBITS−1 cycles.
- Reset mid-operation: all registers return to reset values asynchronously. The pending shadow is lost and `set_filter_o` drops to 0.

## Configuration
- `FILTER_CFG_SEQ_STAGGER_EN` defined:
  - APPLY lasts STAGES cycles; stage j's byte of `set_filter_o` updates on the j-th APPLY edge, stage 0 first.
  - `hold_o` rises with the first byte update.
  - `apply_o` pulses once, after the last byte.
  - The settle count starts after the last byte.
  - Immediate-mode completion of all bytes is at edge k+STAGES.
- Undefined: all bytes update together on a single APPLY edge, as described above.

## Test plan
- Reset, then immediate accept of 0x0000_8C85 with settle=3 → `set_filter_o`=0x0000_8C85 after edge k+1; `apply_o` high 1 cycle; `hold_o` high exactly 3 cycles; ready after k+4.
- STAGES=2, `cfg_i`=0xFFFF_FFFF → `set_filter_o`=0x0000_FFFF.
- Sync mode, `sync_i` pulsed 10 cycles after accept → update exactly 1 cycle after the sync edge; no change before it; `busy_o` high throughout.
- Sync mode, `abort_i` and `sync_i` high on the same edge → IDLE, `set_filter_o` unchanged, no `apply_o`.
- settle=0xFFFF with `abort_i` asserted 5 cycles into SETTLE → `hold_o` falls on that edge; ready next cycle.
- Async reset asserted mid-ARMED and mid-SETTLE → all outputs at reset values immediately.
  - With the STAGGER macro: 4-stage word bytes appear one per cycle, stage 0 first.
